// File: rtl/dma_pkg.sv
// Shared encodings for the multi-channel DMA engine: FSM states,
// transfer directions and memory write-enable patterns.
package dma_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_RD_MEM = 4'd1;
    localparam logic [3:0] ST_RD_CAP = 4'd2;
    localparam logic [3:0] ST_RD_DEV = 4'd3;
    localparam logic [3:0] ST_WR_DEV = 4'd4;
    localparam logic [3:0] ST_WR_MEM = 4'd5;
    localparam logic [3:0] ST_WR_CHK = 4'd6;
    localparam logic [3:0] ST_ADV    = 4'd7;
    localparam logic [3:0] ST_ERR    = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_RD_MEM = ST_RD_MEM,
        S_RD_CAP = ST_RD_CAP,
        S_RD_DEV = ST_RD_DEV,
        S_WR_DEV = ST_WR_DEV,
        S_WR_MEM = ST_WR_MEM,
        S_WR_CHK = ST_WR_CHK,
        S_ADV    = ST_ADV,
        S_ERR    = ST_ERR
    } dma_state_t;

    // Direction bit as seen on rd_wr: 1 moves memory to device.
    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    localparam logic [1:0] DMA_WE_WORD = 2'b11;
    localparam logic [1:0] DMA_WE_NONE = 2'b00;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin channel picker: returns the first requesting channel
// strictly after last_grant, wrapping around to last_grant itself.
module dma_rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int j;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            j = (int'(last_grant) + i) % NUM_CH;
            if (req[j]) begin
                grant_idx = IDX_W'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_multi_channel.sv
// Multi-channel DMA engine: per-channel descriptors share one memory
// port through a round-robin arbiter with a configurable burst length.
// One word at a time passes through data_reg; there is no FIFO.
// Valid/ready: a memory access completes on the edge where dma_en and
// dma_ready are both high; a device word moves on the edge where the
// granted channel's dma_ack and dev_ack are both high.
module dma_multi_channel
    import dma_pkg::*;
#(
    parameter int ADD_LEN   = 16,
    parameter int DATA_LEN  = 16,
    parameter int CNT_LEN   = 16,
    parameter int NUM_CH    = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          rqst,
    input  logic [NUM_CH-1:0]          rd_wr,
    input  logic [NUM_CH*ADD_LEN-1:0]  start_addr,
    input  logic [NUM_CH*CNT_LEN-1:0]  num_words,
    input  logic [NUM_CH-1:0]          prio,
    input  logic [NUM_CH-1:0]          dev_ack,
    input  logic [NUM_CH*DATA_LEN-1:0] dev_in,
    output logic [DATA_LEN-1:0]        dev_out,
    output logic [NUM_CH-1:0]          dma_ack,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          end_flag,
    output logic [NUM_CH-1:0]          error_flag,
    output logic [ADD_LEN-1:0]         dma_addr,
    output logic [DATA_LEN-1:0]        dma_out,
    output logic                       dma_en,
    output logic [1:0]                 dma_we,
    output logic                       dma_priority,
    input  logic [DATA_LEN-1:0]        dma_in,
    input  logic                       dma_ready,
    input  logic                       dma_resp,
    output logic [3:0]                 dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W  = 16;

    dma_state_t          state, state_next;
    logic [NUM_CH-1:0]   busy_r, dir_r, prio_r, end_r, err_r;
    logic [ADD_LEN-1:0]  addr_r [NUM_CH];
    logic [CNT_LEN-1:0]  rem_r  [NUM_CH];
    logic [IDX_W-1:0]    cur_ch, last_grant, grant_idx;
    logic                any_busy;
    logic [DATA_LEN-1:0] data_reg;
    logic [BC_W-1:0]     burst_cnt;
    logic                last_word, burst_done;

    logic [ADD_LEN-1:0]  start_addr_a [NUM_CH];
    logic [CNT_LEN-1:0]  num_words_a  [NUM_CH];
    logic [DATA_LEN-1:0] dev_in_a     [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign start_addr_a[g] = start_addr[g*ADD_LEN +: ADD_LEN];
        assign num_words_a[g]  = num_words[g*CNT_LEN +: CNT_LEN];
        assign dev_in_a[g]     = dev_in[g*DATA_LEN +: DATA_LEN];
    end

    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req        (busy_r),
        .last_grant (last_grant),
        .grant_idx  (grant_idx),
        .any        (any_busy)
    );

    assign last_word  = (rem_r[cur_ch] == CNT_LEN'(1));
    assign burst_done = (BURST_LEN != 0) && (burst_cnt == BC_W'(BURST_LEN - 1));

    assign busy       = busy_r;
    assign end_flag   = end_r;
    assign error_flag = err_r;
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and memory/device port drive, purely from registered state.
    always_comb begin
        state_next   = state;
        dma_en       = 1'b0;
        dma_we       = DMA_WE_NONE;
        dma_addr     = '0;
        dma_out      = '0;
        dev_out      = '0;
        dma_ack      = '0;
        dma_priority = 1'b0;
        if (state != S_IDLE) dma_priority = prio_r[cur_ch];
        case (state)
            S_IDLE: begin
                if (any_busy)
                    state_next = (dir_r[grant_idx] == DIR_RD) ? S_RD_MEM : S_WR_DEV;
            end
            S_RD_MEM: begin
                dma_en   = 1'b1;
                dma_addr = addr_r[cur_ch];
                if (dma_ready) state_next = S_RD_CAP;
            end
            S_RD_CAP: state_next = dma_resp ? S_ERR : S_RD_DEV;
            S_RD_DEV: begin
                dev_out         = data_reg;
                dma_ack[cur_ch] = 1'b1;
                if (dev_ack[cur_ch]) state_next = S_ADV;
            end
            S_WR_DEV: begin
                dma_ack[cur_ch] = 1'b1;
                if (dev_ack[cur_ch]) state_next = S_WR_MEM;
            end
            S_WR_MEM: begin
                dma_en   = 1'b1;
                dma_we   = DMA_WE_WORD;
                dma_out  = data_reg;
                dma_addr = addr_r[cur_ch];
                if (dma_ready) state_next = S_WR_CHK;
            end
            S_WR_CHK: state_next = dma_resp ? S_ERR : S_ADV;
            S_ADV: begin
                if (last_word || burst_done) state_next = S_IDLE;
                else state_next = (dir_r[cur_ch] == DIR_RD) ? S_RD_MEM : S_WR_DEV;
            end
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Channel contexts, grant bookkeeping, data holding register and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r     <= '0;
            dir_r      <= '0;
            prio_r     <= '0;
            end_r      <= '0;
            err_r      <= '0;
            cur_ch     <= '0;
            last_grant <= '0;
            data_reg   <= '0;
            burst_cnt  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                addr_r[c] <= '0;
                rem_r[c]  <= '0;
            end
        end else begin
            end_r <= '0;
            err_r <= '0;
            // Only idle channels accept; a zero-length descriptor completes at once.
            for (int c = 0; c < NUM_CH; c++) begin
                if (rqst[c] && !busy_r[c]) begin
                    if (num_words_a[c] == '0) begin
                        end_r[c] <= 1'b1;
                    end else begin
                        busy_r[c] <= 1'b1;
                        dir_r[c]  <= rd_wr[c];
                        prio_r[c] <= prio[c];
                        addr_r[c] <= start_addr_a[c];
                        rem_r[c]  <= num_words_a[c];
                    end
                end
            end
            case (state)
                S_IDLE: begin
                    if (any_busy) begin
                        cur_ch     <= grant_idx;
                        last_grant <= grant_idx;
                        burst_cnt  <= '0;
                    end
                end
                S_RD_CAP: data_reg <= dma_in;
                S_WR_DEV: if (dev_ack[cur_ch]) data_reg <= dev_in_a[cur_ch];
                S_ADV: begin
                    addr_r[cur_ch] <= addr_r[cur_ch] + ADD_LEN'(1);
                    rem_r[cur_ch]  <= rem_r[cur_ch] - CNT_LEN'(1);
                    burst_cnt      <= burst_cnt + BC_W'(1);
                    if (last_word) begin
                        busy_r[cur_ch] <= 1'b0;
                        end_r[cur_ch]  <= 1'b1;
                    end
                end
                S_ERR: begin
                    busy_r[cur_ch] <= 1'b0;
                    err_r[cur_ch]  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_multi_channel.sv
// Directed bench for dma_multi_channel with two channels, burst length 4,
// a zero-wait memory model and always-ready devices.
module tb_dma_multi_channel;

  // ---------------- clock / reset / DUT ----------------
  logic        clk, reset;
  logic [1:0]  rqst, rd_wr, prio, dev_ack;
  logic [31:0] start_addr, num_words, dev_in;
  logic [15:0] dev_out, dma_addr, dma_out, dma_in;
  logic [1:0]  dma_ack, busy, end_flag, error_flag, dma_we;
  logic        dma_en, dma_priority, dma_ready, dma_resp;
  logic [3:0]  dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dma_multi_channel #(
    .ADD_LEN(16), .DATA_LEN(16), .CNT_LEN(16), .NUM_CH(2), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .rqst(rqst), .rd_wr(rd_wr),
    .start_addr(start_addr), .num_words(num_words), .prio(prio),
    .dev_ack(dev_ack), .dev_in(dev_in), .dev_out(dev_out), .dma_ack(dma_ack),
    .busy(busy), .end_flag(end_flag), .error_flag(error_flag),
    .dma_addr(dma_addr), .dma_out(dma_out), .dma_en(dma_en), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_in(dma_in), .dma_ready(dma_ready),
    .dma_resp(dma_resp), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        pr;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] rx0_q[$];
  logic [15:0] rx1_q[$];
  logic [15:0] wdata [2][8];
  int          widx [2];
  logic [1:0]  ch_dir, hs_prev;
  int          end_cnt [2];
  int          err_cnt [2];
  int          end_cyc [2];
  int          first_en_cyc, cyc, wr_seen, err_at;
  logic        pend_valid, pend_we, pend_err;
  logic [15:0] pend_addr;
  int          n_checks, n_pass;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    exp_q.delete();
    rx0_q.delete();
    rx1_q.delete();
    for (int c = 0; c < 2; c++) begin
      widx[c] = 0; end_cnt[c] = 0; err_cnt[c] = 0; end_cyc[c] = -1;
    end
    first_en_cyc = -1;
    wr_seen = 0;
    err_at = 0;
  endtask

  task automatic set_ch(input int c, input logic dir, input logic [15:0] a,
                        input logic [15:0] nw, input logic p);
    rd_wr[c] = dir;
    start_addr[c*16 +: 16] = a;
    num_words[c*16 +: 16] = nw;
    prio[c] = p;
    ch_dir[c] = dir;
    rqst[c] = 1'b1;
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    int n;
    n = 0;
    while (busy !== 2'b00 && n < budget) begin
      tick();
      n++;
    end
    ok = (busy === 2'b00);
    repeat (4) tick();
  endtask

  // ---------------- memory / device model ----------------
  initial begin
    pend_valid = 1'b0; pend_we = 1'b0; pend_err = 1'b0; pend_addr = '0;
    hs_prev = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < 2; c++) if (hs_prev[c]) widx[c]++;
      dma_in = '0;
      dma_resp = 1'b0;
      if (pend_valid) begin
        if (!pend_we) dma_in = mem_val(pend_addr);
        dma_resp = pend_err;
      end
      pend_valid = 1'b0;
      if (!reset && dma_en && dma_ready) begin
        acc_q.push_back('{we: dma_we, addr: dma_addr, data: dma_out, pr: dma_priority});
        pend_valid = 1'b1;
        pend_we = (dma_we == 2'b11);
        pend_addr = dma_addr;
        pend_err = 1'b0;
        if (pend_we) begin
          wr_seen++;
          if (wr_seen == err_at) pend_err = 1'b1;
        end
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      for (int c = 0; c < 2; c++) begin
        dev_in[c*16 +: 16] = wdata[c][widx[c] % 8];
        hs_prev[c] = !reset && dma_ack[c] && dev_ack[c];
        if (hs_prev[c] && ch_dir[c]) begin
          if (c == 0) rx0_q.push_back(dev_out);
          else        rx1_q.push_back(dev_out);
        end
        if (end_flag[c]) begin
          end_cnt[c]++;
          end_cyc[c] = cyc;
        end
        if (error_flag[c]) err_cnt[c]++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({busy, end_flag, error_flag, dma_ack} !== 8'h00)
      $display("FAIL reset_flags: got %h expected 00", {busy, end_flag, error_flag, dma_ack});
    else n_pass++;
    n_checks++;
    if ({dma_en, dma_we, dma_priority, dma_addr, dma_out, dev_out} !== 52'h0)
      $display("FAIL reset_mem_port: en=%b we=%b pr=%b addr=%h out=%h dev_out=%h expected all 0",
               dma_en, dma_we, dma_priority, dma_addr, dma_out, dev_out);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_ch0();
    logic ok;
    clear_logs();
    set_ch(0, 1'b1, 16'h0100, 16'd3, 1'b0);
    tick();
    rqst = '0;
    n_checks++;
    if (busy[0] !== 1'b1 || dma_en !== 1'b0)
      $display("FAIL rd_accept: busy0=%b dma_en=%b expected 1 0", busy[0], dma_en);
    else n_pass++;
    tick();
    n_checks++;
    if (dma_en !== 1'b1 || dma_addr !== 16'h0100)
      $display("FAIL rd_first_en: dma_en=%b addr=%h expected 1 0100", dma_en, dma_addr);
    else n_pass++;
    wait_idle(100, ok);
    n_checks++;
    if (!ok) $display("FAIL rd_timeout: busy=%b expected 00", busy); else n_pass++;
    exp_q = '{16'h0100, 16'h0101, 16'h0102};
    n_checks++;
    ok = (acc_q.size() == 3);
    if (ok) for (int i = 0; i < 3; i++)
      if (acc_q[i].addr !== exp_q[i] || acc_q[i].we !== 2'b00) ok = 1'b0;
    if (!ok) $display("FAIL rd_addrs: got %0d accesses, first addr %h, expected 3 from 0100",
                      acc_q.size(), (acc_q.size() > 0) ? acc_q[0].addr : 16'hxxxx);
    else n_pass++;
    n_checks++;
    ok = (rx0_q.size() == 3);
    if (ok) for (int i = 0; i < 3; i++) if (rx0_q[i] !== mem_val(exp_q[i])) ok = 1'b0;
    if (!ok) $display("FAIL rd_dev_out: got %0d words, first %h, expected 3 words from %h",
                      rx0_q.size(), (rx0_q.size() > 0) ? rx0_q[0] : 16'hxxxx, mem_val(16'h0100));
    else n_pass++;
    n_checks++;
    if (end_cnt[0] !== 1 || end_cnt[1] !== 0)
      $display("FAIL rd_end_count: ch0=%0d ch1=%0d expected 1 0", end_cnt[0], end_cnt[1]);
    else n_pass++;
    n_checks++;
    if (end_cyc[0] - first_en_cyc !== 12)
      $display("FAIL rd_latency: got %0d expected 12", end_cyc[0] - first_en_cyc);
    else n_pass++;
  endtask

  task automatic test_write_wrap();
    logic ok;
    clear_logs();
    wdata[1][0] = 16'hA5A5;
    wdata[1][1] = 16'h5A5A;
    set_ch(1, 1'b0, 16'hFFFF, 16'd2, 1'b1);
    tick();
    rqst = '0;
    wait_idle(100, ok);
    n_checks++;
    if (!ok) $display("FAIL wr_timeout: busy=%b expected 00", busy); else n_pass++;
    n_checks++;
    if (acc_q.size() != 2)
      $display("FAIL wr_count: got %0d expected 2", acc_q.size());
    else if (acc_q[0].addr !== 16'hFFFF || acc_q[0].data !== 16'hA5A5 || acc_q[0].we !== 2'b11)
      $display("FAIL wr_word0: addr=%h data=%h we=%b expected FFFF A5A5 11",
               acc_q[0].addr, acc_q[0].data, acc_q[0].we);
    else if (acc_q[1].addr !== 16'h0000 || acc_q[1].data !== 16'h5A5A || acc_q[1].we !== 2'b11)
      $display("FAIL wr_word1_wrap: addr=%h data=%h we=%b expected 0000 5A5A 11",
               acc_q[1].addr, acc_q[1].data, acc_q[1].we);
    else n_pass++;
    n_checks++;
    if (end_cnt[1] !== 1 || err_cnt[1] !== 0)
      $display("FAIL wr_flags: end=%0d err=%0d expected 1 0", end_cnt[1], err_cnt[1]);
    else n_pass++;
  endtask

  task automatic test_burst_rr();
    logic ok;
    int bad;
    clear_logs();
    set_ch(0, 1'b1, 16'h0200, 16'd8, 1'b0);
    set_ch(1, 1'b1, 16'h0300, 16'd8, 1'b1);
    tick();
    rqst = '0;
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL rr_timeout: busy=%b expected 00", busy); else n_pass++;
    // ch1 went last, so ch0 wins first; bursts of 4 then alternate.
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back(((b % 2) ? 16'h0300 : 16'h0200) + 16'((b / 2) * 4 + i));
    n_checks++;
    bad = -1;
    if (acc_q.size() != 16) bad = 99;
    else for (int i = 0; i < 16; i++)
      if (bad < 0 && (acc_q[i].addr !== exp_q[i] || acc_q[i].pr !== exp_q[i][8])) bad = i;
    if (bad >= 0)
      $display("FAIL rr_order: %0d accesses, first bad index %0d, expected 16 in 4-word alternating bursts",
               acc_q.size(), bad);
    else n_pass++;
    n_checks++;
    ok = (rx0_q.size() == 8) && (rx1_q.size() == 8);
    if (ok) for (int i = 0; i < 8; i++)
      if (rx0_q[i] !== mem_val(16'h0200 + 16'(i)) || rx1_q[i] !== mem_val(16'h0300 + 16'(i))) ok = 1'b0;
    if (!ok) $display("FAIL rr_dev_out: ch0 %0d words ch1 %0d words, expected 8 each matching memory",
                      rx0_q.size(), rx1_q.size());
    else n_pass++;
    n_checks++;
    if (end_cnt[0] !== 1 || end_cnt[1] !== 1)
      $display("FAIL rr_end_flags: ch0=%0d ch1=%0d expected 1 1", end_cnt[0], end_cnt[1]);
    else n_pass++;
  endtask

  task automatic test_error();
    logic ok;
    clear_logs();
    wdata[0][0] = 16'h1111;
    wdata[0][1] = 16'h2222;
    wdata[0][2] = 16'h3333;
    err_at = 2;
    set_ch(0, 1'b0, 16'h0400, 16'd3, 1'b0);
    set_ch(1, 1'b1, 16'h0500, 16'd2, 1'b1);
    tick();
    rqst = '0;
    wait_idle(200, ok);
    n_checks++;
    if (!ok) $display("FAIL err_timeout: busy=%b expected 00", busy); else n_pass++;
    n_checks++;
    if (err_cnt[0] !== 1 || end_cnt[0] !== 0 || busy[0] !== 1'b0)
      $display("FAIL err_ch0_flags: err=%0d end=%0d busy=%b expected 1 0 0",
               err_cnt[0], end_cnt[0], busy[0]);
    else n_pass++;
    n_checks++;
    if (acc_q.size() != 4)
      $display("FAIL err_access_count: got %0d expected 4", acc_q.size());
    else if (acc_q[0].addr !== 16'h0400 || acc_q[0].data !== 16'h1111 ||
             acc_q[1].addr !== 16'h0401 || acc_q[1].data !== 16'h2222 ||
             acc_q[2].addr !== 16'h0500 || acc_q[3].addr !== 16'h0501)
      $display("FAIL err_access_seq: got %h/%h %h/%h %h %h expected 0400/1111 0401/2222 0500 0501",
               acc_q[0].addr, acc_q[0].data, acc_q[1].addr, acc_q[1].data, acc_q[2].addr, acc_q[3].addr);
    else n_pass++;
    n_checks++;
    if (end_cnt[1] !== 1 || err_cnt[1] !== 0 || rx1_q.size() != 2)
      $display("FAIL err_ch1_proceeds: end=%0d err=%0d words=%0d expected 1 0 2",
               end_cnt[1], err_cnt[1], rx1_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    clear_logs();
    set_ch(0, 1'b1, 16'h0800, 16'd0, 1'b0);
    tick();
    rqst = '0;
    n_checks++;
    if (end_flag[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL zero_end_pulse: end0=%b busy0=%b expected 1 0", end_flag[0], busy[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (end_flag[0] !== 1'b0)
      $display("FAIL zero_pulse_width: end0=%b expected 0", end_flag[0]);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (acc_q.size() != 0 || end_cnt[0] !== 1)
      $display("FAIL zero_no_access: accesses=%0d ends=%0d expected 0 1", acc_q.size(), end_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n;
    clear_logs();
    set_ch(0, 1'b1, 16'h0600, 16'd8, 1'b1);
    tick();
    rqst = '0;
    n = 0;
    while (acc_q.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (acc_q.size() < 2) $display("FAIL mid_progress: got %0d accesses expected 2", acc_q.size());
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, end_flag, error_flag, dma_ack, dma_en, dma_we, dma_priority} !== 11'h0 ||
        {dma_addr, dma_out, dev_out} !== 48'h0 || dbg_state !== 4'd0)
      $display("FAIL mid_reset_outputs: busy=%b en=%b addr=%h dev_out=%h ack=%b pr=%b state=%0d expected all 0",
               busy, dma_en, dma_addr, dev_out, dma_ack, dma_priority, dbg_state);
    else n_pass++;
    tick();
    reset = 1'b0;
    clear_logs();
    repeat (5) tick();
    n_checks++;
    if (acc_q.size() != 0 || end_cnt[0] !== 0 || err_cnt[0] !== 0)
      $display("FAIL mid_discard: accesses=%0d end=%0d err=%0d expected 0 0 0",
               acc_q.size(), end_cnt[0], err_cnt[0]);
    else n_pass++;
    set_ch(1, 1'b1, 16'h0700, 16'd1, 1'b0);
    tick();
    rqst = '0;
    wait_idle(50, ok);
    n_checks++;
    if (!ok || acc_q.size() != 1 || rx1_q.size() != 1)
      $display("FAIL restart_count: ok=%b accesses=%0d words=%0d expected 1 1 1",
               ok, acc_q.size(), rx1_q.size());
    else if (acc_q[0].addr !== 16'h0700 || rx1_q[0] !== mem_val(16'h0700) || end_cnt[1] !== 1)
      $display("FAIL restart_data: addr=%h data=%h end=%0d expected 0700 %h 1",
               acc_q[0].addr, rx1_q[0], end_cnt[1], mem_val(16'h0700));
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    rqst = '0; rd_wr = '0; prio = '0; dev_ack = 2'b11;
    start_addr = '0; num_words = '0; dev_in = '0;
    dma_in = '0; dma_ready = 1'b1; dma_resp = 1'b0;
    ch_dir = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 8; i++) wdata[c][i] = 16'h0;
    clear_logs();
    test_reset();
    test_read_ch0();
    test_write_wrap();
    test_burst_rr();
    test_error();
    test_zero_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
